// File: rtl/lsu_dmem_pkg.sv
// Shared types and helpers for the RV64I load/store data memory.
// Width codes, response error codes, access size decode and load extension.
package lsu_pkg;

    typedef enum logic [2:0] {
        MEM_B   = 3'b000,
        MEM_H   = 3'b001,
        MEM_W   = 3'b010,
        MEM_D   = 3'b011,
        MEM_BU  = 3'b100,
        MEM_HU  = 3'b101,
        MEM_WU  = 3'b110,
        MEM_ILL = 3'b111
    } wid_e;

    typedef enum logic [1:0] {
        ERR_OK          = 2'b00,
        ERR_ILLEGAL_WID = 2'b01,
        ERR_MISALIGNED  = 2'b10
    } resp_err_e;

    // Access size in bytes: 1/2/4/8 from the low two width bits.
    function automatic logic [3:0] size_of(input logic [2:0] wid);
        return 4'd1 << wid[1:0];
    endfunction

    // Sign or zero extend a right-aligned load value according to its width code.
    function automatic logic [63:0] extend(input logic [2:0] wid, input logic [63:0] raw);
        logic [63:0] r;
        r = '0;
        case (wid)
            MEM_B:   r = {{56{raw[7]}},  raw[7:0]};
            MEM_H:   r = {{48{raw[15]}}, raw[15:0]};
            MEM_W:   r = {{32{raw[31]}}, raw[31:0]};
            MEM_D:   r = raw;
            MEM_BU:  r = {56'b0, raw[7:0]};
            MEM_HU:  r = {48'b0, raw[15:0]};
            MEM_WU:  r = {32'b0, raw[31:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// Request/response bundle between the MEM stage (master) and lsu_dmem (slave).
interface lsu_dmem_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic [2:0]            req_wid_i;
    logic                  resp_valid_o;
    logic [DATA_WIDTH-1:0] resp_rdata_o;
    logic [1:0]            resp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wid_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wid_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );
endinterface

// File: rtl/lsu_dmem_bank.sv
// Byte-lane-enabled synchronous array: per-lane write enable, registered read.
// Contents are never reset.
module dmem_bank #(
    parameter int NB = 8,
    parameter int AW = 13
) (
    input  logic            clk,
    input  logic            we,
    input  logic [NB-1:0]   be,
    input  logic [AW-1:0]   addr,
    input  logic [NB*8-1:0] wdata,
    output logic [NB*8-1:0] rdata
);
    logic [NB-1:0][7:0] mem [2**AW];

    // Write enabled lanes and register the addressed word every cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr][i] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/lsu_dmem.sv
// RV64I data memory front end: decode, error check, optional split of
// word-crossing accesses into two beats, and load extension.
// Optional feature: define DMEM_MISALIGN_SPLIT_EN to split crossing accesses
// instead of rejecting them as MISALIGNED.
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    lsu_dmem_if.slave  bus
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int NB2 = 2 * NB;
    localparam int OW  = $clog2(NB);
    localparam int WW  = ADDR_WIDTH - OW;
    localparam int DW2 = 2 * DATA_WIDTH;

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic {IDLE, SPLIT} state_e;
    state_e state_q, state_d;

    logic                  ready, accept, illegal, crossing, go_split;
    logic [OW-1:0]         off;
    logic [WW-1:0]         word;
    logic [3:0]            size;
    logic [NB2-1:0]        be2;
    logic [DW2-1:0]        wd2;
    resp_err_e             err_code;

    // Second-beat request state captured at accept.
    logic                  lat_we;
    logic [WW-1:0]         lat_word;
    logic [NB-1:0]         lat_be_hi;
    logic [DATA_WIDTH-1:0] lat_wd_hi;
    logic [2:0]            lat_wid;
    logic [OW-1:0]         lat_off;

    // Response pipeline state.
    logic                  resp_valid_q, resp_load_q, resp_split_q;
    resp_err_e             resp_err_q;
    logic [2:0]            resp_wid_q;
    logic [OW-1:0]         resp_off_q;
    logic [DATA_WIDTH-1:0] lo_q;

    logic                  bank_we;
    logic [NB-1:0]         bank_be;
    logic [WW-1:0]         bank_addr;
    logic [DATA_WIDTH-1:0] bank_wd, bank_rd;
    logic [DW2-1:0]        pair;
    logic [63:0]           ext;

    assign off      = bus.req_addr_i[OW-1:0];
    assign word     = bus.req_addr_i[ADDR_WIDTH-1:OW];
    assign size     = size_of(bus.req_wid_i);
    assign accept   = bus.req_valid_i && ready;
    assign illegal  = (bus.req_wid_i == MEM_ILL) ||
                      ((DATA_WIDTH == 32) && (bus.req_wid_i == MEM_D || bus.req_wid_i == MEM_WU));
    assign crossing = (int'(off) + int'(size)) > NB;
    assign go_split = accept && !illegal && crossing && SPLIT_EN;
    assign err_code = illegal ? ERR_ILLEGAL_WID :
                      (crossing && !SPLIT_EN) ? ERR_MISALIGNED : ERR_OK;

    // Lane mask and data over a two-word window: low half is beat 1, high half beat 2.
    assign be2 = NB2'((16'd1 << size) - 16'd1) << off;
    assign wd2 = DW2'(bus.req_wdata_i) << {off, 3'b000};

    // Next state and handshake ready.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = !rst;
                if (go_split) state_d = SPLIT;
            end
            SPLIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Array port: second beat in SPLIT, otherwise the accepted error-free request.
    always_comb begin
        bank_we   = 1'b0;
        bank_be   = '0;
        bank_addr = word;
        bank_wd   = wd2[DATA_WIDTH-1:0];
        if (state_q == SPLIT) begin
            bank_we   = lat_we;
            bank_be   = lat_be_hi;
            bank_addr = lat_word + WW'(1);
            bank_wd   = lat_wd_hi;
        end else if (accept && err_code == ERR_OK) begin
            bank_we = bus.req_we_i;
            bank_be = be2[NB-1:0];
        end
    end

    dmem_bank #(.NB(NB), .AW(WW)) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .be    (bank_be),
        .addr  (bank_addr),
        .wdata (bank_wd),
        .rdata (bank_rd)
    );

    // Latch the second-beat request and hold the first-beat read word.
    always_ff @(posedge clk) begin
        if (go_split) begin
            lat_we    <= bus.req_we_i;
            lat_word  <= word;
            lat_be_hi <= be2[NB2-1:NB];
            lat_wd_hi <= wd2[DW2-1:DATA_WIDTH];
            lat_wid   <= bus.req_wid_i;
            lat_off   <= off;
        end
        if (state_q == SPLIT) lo_q <= bank_rd;
    end

    // Response register: one pulse per accepted request, split ones a cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= ERR_OK;
            resp_load_q  <= 1'b0;
            resp_split_q <= 1'b0;
            resp_wid_q   <= '0;
            resp_off_q   <= '0;
        end else if (state_q == SPLIT) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= ERR_OK;
            resp_load_q  <= !lat_we;
            resp_split_q <= 1'b1;
            resp_wid_q   <= lat_wid;
            resp_off_q   <= lat_off;
        end else begin
            resp_valid_q <= accept && !go_split;
            resp_err_q   <= accept ? err_code : ERR_OK;
            resp_load_q  <= accept && !bus.req_we_i && err_code == ERR_OK;
            resp_split_q <= 1'b0;
            resp_wid_q   <= bus.req_wid_i;
            resp_off_q   <= off;
        end
    end

    // Align the registered read (both beats when split) and extend.
    always_comb begin
        pair = resp_split_q ? {bank_rd, lo_q} : {{DATA_WIDTH{1'b0}}, bank_rd};
        pair = pair >> {resp_off_q, 3'b000};
        ext  = extend(resp_wid_q, 64'(pair[DATA_WIDTH-1:0]));
    end

    assign bus.req_ready_o  = ready;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.resp_rdata_o = (resp_valid_q && resp_load_q) ? ext[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: a 64-bit instance for the main path and a
// 32-bit instance for width legality. Split-mode expectations follow
// DMEM_MISALIGN_SPLIT_EN.
module tb_lsu_dmem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_dmem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) bus0 ();
    lsu_dmem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus1 ();

    lsu_dmem #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) u_dut64 (.clk(clk), .rst(rst), .bus(bus0));
    lsu_dmem #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) u_dut32 (.clk(clk), .rst(rst), .bus(bus1));

    // Shared request drive; sel picks which instance sees the valid.
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [2:0]  req_wid = '0;

    assign bus0.req_valid_i = req_valid && !sel;
    assign bus0.req_we_i    = req_we;
    assign bus0.req_addr_i  = req_addr;
    assign bus0.req_wdata_i = req_wdata;
    assign bus0.req_wid_i   = req_wid;
    assign bus1.req_valid_i = req_valid && sel;
    assign bus1.req_we_i    = req_we;
    assign bus1.req_addr_i  = req_addr;
    assign bus1.req_wdata_i = req_wdata[31:0];
    assign bus1.req_wid_i   = req_wid;

    logic        obs_ready, obs_valid;
    logic [63:0] obs_rdata;
    logic [1:0]  obs_err;
    assign obs_ready = sel ? bus1.req_ready_o  : bus0.req_ready_o;
    assign obs_valid = sel ? bus1.resp_valid_o : bus0.resp_valid_o;
    assign obs_rdata = sel ? 64'(bus1.resp_rdata_o) : bus0.resp_rdata_o;
    assign obs_err   = sel ? bus1.resp_err_o   : bus0.resp_err_o;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated request issued at a negedge; checks latency, payload and single pulse.
    task automatic txn(input logic s, input logic we, input logic [15:0] a, input logic [63:0] d,
                       input logic [2:0] w, input logic [63:0] er, input logic [1:0] ee,
                       input int lat, input string tag);
        sel = s; req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wid = w;
        @(negedge clk);
        req_valid = 1'b0;
        if (lat == 2) begin
            chk({tag, "_rdy_split"}, 64'(obs_ready), 64'd0);
            chk({tag, "_v_early"},   64'(obs_valid), 64'd0);
            @(negedge clk);
        end
        chk({tag, "_v"},     64'(obs_valid), 64'd1);
        chk({tag, "_rdata"}, obs_rdata, er);
        chk({tag, "_err"},   64'(obs_err), 64'(ee));
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(obs_valid), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(obs_ready), 64'd0);
        chk("rst_valid", 64'(obs_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 64'(obs_ready), 64'd1);
        chk("rel_rdata", obs_rdata, 64'd0);
        chk("rel_err",   64'(obs_err), 64'd0);

        // Aligned double store and load.
        txn(0, 1, 16'h0010, 64'h1122334455667788, 3'b011, 64'd0, 2'b00, 1, "sd10");
        txn(0, 0, 16'h0010, 64'd0, 3'b011, 64'h1122334455667788, 2'b00, 1, "ld10");

        // Back-to-back SB then LB to the same word.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0013; req_wdata = 64'h80; req_wid = 3'b000;
        @(negedge clk);
        chk("b2b_sb_v",     64'(obs_valid), 64'd1);
        chk("b2b_sb_rdata", obs_rdata, 64'd0);
        req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_lb_v",     64'(obs_valid), 64'd1);
        chk("b2b_lb_rdata", obs_rdata, 64'hFFFFFFFFFFFFFF80);
        @(negedge clk);
        chk("b2b_pulse", 64'(obs_valid), 64'd0);

        txn(0, 0, 16'h0013, 64'd0, 3'b100, 64'h80, 2'b00, 1, "lbu13");
        txn(0, 0, 16'h0010, 64'd0, 3'b011, 64'h1122334480667788, 2'b00, 1, "ld10b");
        txn(0, 0, 16'h0011, 64'd0, 3'b001, 64'h6677, 2'b00, 1, "lh11");
        txn(0, 0, 16'h0012, 64'd0, 3'b001, 64'hFFFFFFFFFFFF8066, 2'b00, 1, "lh12");
        txn(0, 0, 16'h0012, 64'd0, 3'b101, 64'h8066, 2'b00, 1, "lhu12");
        txn(0, 0, 16'h0014, 64'd0, 3'b010, 64'h11223344, 2'b00, 1, "lw14");
        txn(0, 0, 16'h0010, 64'd0, 3'b010, 64'hFFFFFFFF80667788, 2'b00, 1, "lw10");
        txn(0, 0, 16'h0010, 64'd0, 3'b110, 64'h80667788, 2'b00, 1, "lwu10");

        // Illegal width, including priority over a crossing address.
        txn(0, 0, 16'h0010, 64'd0, 3'b111, 64'd0, 2'b01, 1, "ill10");
        txn(0, 1, 16'h000F, 64'hFFFF, 3'b111, 64'd0, 2'b01, 1, "ill0f");

        txn(0, 1, 16'h0008, 64'd0, 3'b011, 64'd0, 2'b00, 1, "sd08");
        txn(0, 1, 16'h0000, 64'd0, 3'b011, 64'd0, 2'b00, 1, "sd00");
`ifdef DMEM_MISALIGN_SPLIT_EN
        txn(0, 1, 16'h000E, 64'hDEADBEEF, 3'b010, 64'd0, 2'b00, 2, "sw0e");
        txn(0, 0, 16'h000E, 64'd0, 3'b010, 64'hFFFFFFFFDEADBEEF, 2'b00, 2, "lw0e");
        txn(0, 0, 16'h0008, 64'd0, 3'b011, 64'hBEEF000000000000, 2'b00, 1, "ld08");
        txn(0, 0, 16'h0010, 64'd0, 3'b011, 64'h112233448066DEAD, 2'b00, 1, "ld10c");
        // Top-of-memory wrap: beat 2 lands in word 0.
        txn(0, 1, 16'hFFFF, 64'hA55A, 3'b001, 64'd0, 2'b00, 2, "shtop");
        txn(0, 0, 16'h0000, 64'd0, 3'b011, 64'hA5, 2'b00, 1, "ld00");
        txn(0, 0, 16'hFFFF, 64'd0, 3'b101, 64'hA55A, 2'b00, 2, "lhutop");
        // Reset while in SPLIT: no response, first-beat lanes remain written.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h000E; req_wdata = 64'h11223344; req_wid = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstsplit_rdy", 64'(obs_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstsplit_v", 64'(obs_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstsplit_rdy_rel", 64'(obs_ready), 64'd1);
        chk("rstsplit_v_rel",   64'(obs_valid), 64'd0);
        txn(0, 0, 16'h0008, 64'd0, 3'b011, 64'h3344000000000000, 2'b00, 1, "ld08r");
        txn(0, 0, 16'h0010, 64'd0, 3'b011, 64'h112233448066DEAD, 2'b00, 1, "ld10r");
`else
        txn(0, 1, 16'h000E, 64'hDEADBEEF, 3'b010, 64'd0, 2'b10, 1, "sw0e");
        txn(0, 0, 16'h000E, 64'd0, 3'b010, 64'd0, 2'b10, 1, "lw0e");
        txn(0, 0, 16'h0008, 64'd0, 3'b011, 64'd0, 2'b00, 1, "ld08");
        txn(0, 0, 16'h0010, 64'd0, 3'b011, 64'h1122334480667788, 2'b00, 1, "ld10c");
        txn(0, 1, 16'hFFFF, 64'hA55A, 3'b001, 64'd0, 2'b10, 1, "shtop");
        txn(0, 0, 16'h0000, 64'd0, 3'b011, 64'd0, 2'b00, 1, "ld00");
`endif

        // 32-bit instance: D and WU are illegal and must not write.
        txn(1, 1, 16'h0004, 64'h12345678, 3'b010, 64'd0, 2'b00, 1, "w32_sw");
        txn(1, 1, 16'h0004, 64'hCAFEBABE, 3'b011, 64'd0, 2'b01, 1, "w32_sd");
        txn(1, 0, 16'h0004, 64'd0, 3'b010, 64'h12345678, 2'b00, 1, "w32_lw");
        txn(1, 0, 16'h0004, 64'd0, 3'b011, 64'd0, 2'b01, 1, "w32_ld");
        txn(1, 0, 16'h0004, 64'd0, 3'b110, 64'd0, 2'b01, 1, "w32_lwu");
        txn(1, 0, 16'h0006, 64'd0, 3'b001, 64'h1234, 2'b00, 1, "w32_lh6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
